// File: rtl/clk_edge_meter.sv
// clk_edge_meter: measures the period and high time of a divided clock, in clk cycles.
// Define EDGE_METER_SYNC_EN to insert a two-flop synchronizer ahead of the edge detector.
module clk_edge_meter #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clk_in,
    input  logic          meas_en,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_cnt,
    output logic          period_valid,
    output logic          timeout
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    if (TIMEOUT < 2 || (TIMEOUT >> CW) != 0) begin : g_bad_timeout
        $error("clk_edge_meter: TIMEOUT=%0d outside 2 .. 2^CW-1", TIMEOUT);
    end

    state_t        state_q, state_d;
    logic          s2_q, s2_d, d_q, d_d, rise;
    logic          rise_q, rise_d, fall_q, fall_d, pv_q, pv_d, to_q, to_d;
    logic [CW-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, per_q, per_d, hi_q, hi_d;

`ifdef EDGE_METER_SYNC_EN
    logic s1_q, s1_d;
    assign s1_d = clk_in;
    assign s2_d = s1_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) s1_q <= 1'b0;
        else       s1_q <= s1_d;
    end
`else
    assign s2_d = clk_in;
`endif

    // Edges come from the synchronized sample; the FSM reacts in the same cycle
    // the edge pulse is registered, so period_valid coincides with rise_pulse.
    always_comb begin
        d_d     = s2_q;
        rise    = s2_q & ~d_q;
        rise_d  = rise;
        fall_d  = ~s2_q & d_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        per_d   = per_q;
        hi_d    = hi_q;
        pv_d    = 1'b0;
        to_d    = to_q;
        if (!meas_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            to_d    = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = ARM;
        end else if (rise) begin
            if (state_q == MEAS) begin
                per_d = cnt_q + CW'(1);
                hi_d  = hcnt_q;
                pv_d  = 1'b1;
            end
            state_d = MEAS;
            cnt_d   = '0;
            hcnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            state_d = ARM;
            to_d    = 1'b1;
            cnt_d   = '0;
            hcnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (state_q == MEAS) hcnt_d = hcnt_q + CW'(d_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            s2_q    <= 1'b0;
            d_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            pv_q    <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            per_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            s2_q    <= s2_d;
            d_q     <= d_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pv_q    <= pv_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
        end
    end

    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign period       = per_q;
    assign high_cnt     = hi_q;
    assign period_valid = pv_q;
    assign timeout      = to_q;
endmodule

// File: tb/tb_clk_edge_meter.sv
// tb_clk_edge_meter: directed and random clk_in waveforms checked against a time-based model
// that derives edges, periods and high times straight from the driven waveform history.
module tb_clk_edge_meter;
    localparam int CW      = 16;
    localparam int TIMEOUT = 16;
`ifdef EDGE_METER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0, rstn = 1'b0, clk_in = 1'b1, meas_en = 1'b0;
    logic          rise_pulse, fall_pulse, period_valid, timeout;
    logic [CW-1:0] period, high_cnt;

    clk_edge_meter #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .clk_in(clk_in), .meas_en(meas_en),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .period(period),
        .high_cnt(high_cnt), .period_valid(period_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cin [0:8191];
    int tk = 0, rst_upto = -1, checks = 0, failures = 0;
    int last = 0, ref_t = 0, per_exp = 0, hi_exp = 0;
    bit on = 0, have_last = 0, to_exp = 0, rexp = 0, fexp = 0, pvexp = 0;

    // clk_in value driven in step k; anything captured under reset never reaches the detector
    function automatic int cv(int k);
        return (k < 0 || k <= rst_upto) ? 0 : cin[k];
    endfunction

    function automatic int high_between(int a, int b);
        int s = 0;
        for (int k = a - LAT; k < b - LAT; k++) s += cv(k);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at step %0d", tag, obs, exp, tk);
        end
    endtask

    task automatic check_outputs();
        chk("rise_pulse", 32'(rise_pulse), 32'(rexp));
        chk("fall_pulse", 32'(fall_pulse), 32'(fexp));
        chk("period_valid", 32'(period_valid), 32'(pvexp));
        chk("timeout", 32'(timeout), 32'(to_exp));
        chk("period", 32'(period), 32'(per_exp));
        chk("high_cnt", 32'(high_cnt), 32'(hi_exp));
    endtask

    task automatic step(input logic ci, input logic me);
        clk_in  = ci;
        meas_en = me;
        cin[tk] = int'(ci);
        @(posedge clk);
        #1;
        tk++;
        pvexp = 0;
        if (!rstn) begin
            rst_upto = tk - 1;
            {on, have_last, to_exp, rexp, fexp} = '0;
            per_exp = 0;
            hi_exp  = 0;
        end else begin
            rexp = cv(tk - LAT) == 1 && cv(tk - LAT - 1) == 0;
            fexp = cv(tk - LAT) == 0 && cv(tk - LAT - 1) == 1;
            if (!me) begin
                on = 0; have_last = 0; to_exp = 0;
            end else if (!on) begin
                on = 1; have_last = 0; ref_t = tk;
            end else if (rexp) begin
                if (have_last) begin
                    pvexp   = 1;
                    per_exp = tk - last;
                    hi_exp  = high_between(last, tk);
                end
                have_last = 1; last = tk; ref_t = tk;
            end else if (tk - ref_t == TIMEOUT) begin
                to_exp = 1; have_last = 0; ref_t = tk;
            end
        end
        check_outputs();
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < h + l; i++) step(i < h, 1'b1);
    endtask

    task automatic reset_pulse(input logic ci, input logic me);
        rstn = 1'b0;
        #1;
        {on, have_last, to_exp, rexp, fexp, pvexp} = '0;
        per_exp = 0;
        hi_exp  = 0;
        check_outputs();
        step(ci, me);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at step %0d", tk);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, h, l, drop;
        bit got;
        // reset with clk_in high: one rise pulse after release
        repeat (3) step(1'b1, 1'b0);
        rstn = 1'b1;
        repeat (6) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        // clk_in stuck low: timeout after TIMEOUT cycles in ARM, no period_valid
        repeat (40) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        // divide-by-8, 50% duty
        wave(4, 4, 6);
        // meas_en dropped exactly in the cycle the rise is detected
        for (int i = 0; i < 8; i++) step(i < 4, i != LAT - 1);
        wave(4, 4, 4);
        // reset mid-period discards the partial measurement
        repeat (2) step(1'b1, 1'b1);
        reset_pulse(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        wave(4, 4, 4);
        // rise latency from a quiet low input
        repeat (6) step(1'b0, 1'b1);
        t0 = tk;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1, 1'b1);
            if (rise_pulse === 1'b1) got = 1;
        end
        chk("rise_latency", got ? 32'(tk - t0) : 32'd99, 32'(LAT));
        repeat (7) step(1'b0, 1'b1);
        // asymmetric 3 high / 7 low
        wave(3, 7, 5);
        // timeout from MEAS stays sticky through later valid edges
        repeat (30) step(1'b0, 1'b1);
        wave(4, 4, 3);
        step(1'b0, 1'b0);
        // random waveforms with occasional single-cycle enable drops
        for (int p = 0; p < 30; p++) begin
            h = $urandom_range(1, 7);
            l = $urandom_range(1, 7);
            drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, h + l - 1) : -1;
            for (int i = 0; i < h + l; i++) step(i < h, i != drop);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
